// File: rtl/axil_slave_if_if.sv
// AXI4-Lite bus bundle between an initiator and the register-bank slave front-end.
interface axil_slave_if_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;

  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;

  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;

  logic [ADDR_WIDTH-1:0] s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;

  logic [31:0]           s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, output s_awready,
    input  s_wdata, s_wstrb, s_wvalid, output s_wready,
    output s_bresp, s_bvalid, input s_bready,
    input  s_araddr, s_arvalid, output s_arready,
    output s_rdata, s_rresp, s_rvalid, input s_rready
  );

  modport master (
    output s_awaddr, s_awvalid, input s_awready,
    output s_wdata, s_wstrb, s_wvalid, input s_wready,
    input  s_bresp, s_bvalid, output s_bready,
    output s_araddr, s_arvalid, input s_arready,
    input  s_rdata, s_rresp, s_rvalid, output s_rready
  );
endinterface

// File: rtl/axil_slave_if.sv
// AXI4-Lite slave front-end for the 16-entry register bank: write = AW/W capture, one-cycle
// write_en, then B; read = AR capture, one settle cycle, then R. All outputs registered.
module axil_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int RO_IDX     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  axil_slave_if_if.slave        s,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]           write_data,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [31:0]           read_data
);
  localparam int                    IDX_W       = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT  = ADDR_WIDTH'(4 * NUM_REGS);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  write_en_q, write_en_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [31:0]           write_data_q, write_data_d;

  r_state_t              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_fire, w_fire, ar_fire;
  logic [ADDR_WIDTH-1:0] wr_addr_sel;
  logic [31:0]           wr_data_sel;
  logic [3:0]            wr_strb_sel;
  logic                  wr_legal;
  logic                  rd_in_range;

  assign aw_fire = s.s_awvalid & awready_q;
  assign w_fire  = s.s_wvalid  & wready_q;
  assign ar_fire = s.s_arvalid & arready_q;

  // The half that arrived earlier comes from its holding register, the other straight off the bus.
  assign wr_addr_sel = aw_held_q ? awaddr_q : s.s_awaddr;
  assign wr_data_sel = w_held_q  ? wdata_q  : s.s_wdata;
  assign wr_strb_sel = w_held_q  ? wstrb_q  : s.s_wstrb;

  assign wr_legal = (wr_addr_sel < ADDR_LIMIT)
                 && (wr_addr_sel[IDX_W+1:2] != IDX_W'(RO_IDX))
                 && (wr_strb_sel == 4'hF);
  assign rd_in_range = (read_addr_q < ADDR_LIMIT);

  always_comb begin
    w_state_d    = w_state_q;
    aw_held_d    = aw_held_q;
    w_held_d     = w_held_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;

    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = s.s_awaddr;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s.s_wdata;
          wstrb_d  = s.s_wstrb;
        end
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          w_state_d    = W_EXEC;
          write_en_d   = wr_legal;
          write_addr_d = wr_addr_sel;
          write_data_d = wr_data_sel;
          bresp_d      = wr_legal ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_EXEC: begin
        bvalid_d  = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (s.s_bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q    <= W_IDLE;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      w_state_q    <= w_state_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  // read_data is sampled at the end of R_ADDR, before any same-cycle bank write lands.
  always_comb begin
    r_state_d   = r_state_q;
    read_addr_d = read_addr_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          read_addr_d = s.s_araddr;
          r_state_d   = R_ADDR;
        end
      end
      R_ADDR: begin
        rdata_d   = rd_in_range ? read_data : 32'h0;
        rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        rvalid_d  = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (s.s_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q   <= R_IDLE;
      arready_q   <= 1'b0;
      read_addr_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
    end else begin
      r_state_q   <= r_state_d;
      arready_q   <= arready_d;
      read_addr_q <= read_addr_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
    end
  end

  assign s.s_awready = awready_q;
  assign s.s_wready  = wready_q;
  assign s.s_bvalid  = bvalid_q;
  assign s.s_bresp   = bresp_q;
  assign s.s_arready = arready_q;
  assign s.s_rvalid  = rvalid_q;
  assign s.s_rdata   = rdata_q;
  assign s.s_rresp   = rresp_q;

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign read_addr  = read_addr_q;
endmodule

// File: tb/tb_axil_slave_if.sv
// Directed bench for axil_slave_if with a behavioural register bank and response scoreboards.
module tb_axil_slave_if;
  logic        clk = 1'b0;
  logic        reset;
  logic        write_en;
  logic [31:0] write_addr, write_data, read_addr, read_data;

  always #5 clk = ~clk;

  axil_slave_if_if #(.ADDR_WIDTH(32)) bus ();

  axil_slave_if #(.ADDR_WIDTH(32), .NUM_REGS(16), .RO_IDX(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (bus),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr  (read_addr),
    .read_data  (read_data)
  );

  // Bank model: index 3 holds a fixed ALU result.
  logic [31:0] bank [16] = '{32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0,
                             32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] shadow [16] = '{32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0,
                               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

  assign read_data = bank[read_addr[5:2]];
  always @(posedge clk) if (write_en) bank[write_addr[5:2]] <= write_data;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } rd_t;

  wr_t        wr_q [$];
  logic [1:0] b_q  [$];
  rd_t        r_q  [$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  wr_t  mon_e;
  logic wen_prev = 1'b0;
  always @(negedge clk) begin
    if (write_en) begin
      check("wen_single", 32'(wen_prev), 32'd0);
      if (wr_q.size() == 0) check("wen_unexpected", 32'(write_en), 32'd0);
      else begin
        mon_e = wr_q.pop_front();
        check("wen_addr", write_addr, mon_e.addr);
        check("wen_data", write_data, mon_e.data);
      end
    end
    wen_prev = write_en;
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int b_hold);
    logic       legal, aw_f, w_f;
    logic [1:0] resp0, exp_resp;
    wr_t        w;
    int         cyc;
    legal = (addr < 32'h40) && (addr[5:2] != 4'd3) && (strb == 4'hF);
    b_q.push_back(legal ? 2'b00 : 2'b10);
    if (legal) begin
      w.addr = addr;
      w.data = data;
      wr_q.push_back(w);
    end
    bus.s_awaddr  = addr;
    bus.s_wdata   = data;
    bus.s_wstrb   = strb;
    bus.s_wvalid  = 1'b1;
    bus.s_awvalid = (w_lead == 0);
    bus.s_bready  = 1'b0;
    cyc = 0;
    while ((bus.s_awvalid || bus.s_wvalid || cyc < w_lead) && cyc < 40) begin
      aw_f = bus.s_awvalid && bus.s_awready;
      w_f  = bus.s_wvalid && bus.s_wready;
      @(negedge clk);
      cyc++;
      if (aw_f) bus.s_awvalid = 1'b0;
      if (w_f) begin
        bus.s_wvalid = 1'b0;
        if (w_lead > 0) check("wready_drop", 32'(bus.s_wready), 32'd0);
      end
      if (w_lead > 0 && cyc == w_lead) bus.s_awvalid = 1'b1;
    end
    if (bus.s_awvalid || bus.s_wvalid) begin
      check("write_hs_timeout", 32'({bus.s_awvalid, bus.s_wvalid}), 32'd0);
      bus.s_awvalid = 1'b0;
      bus.s_wvalid  = 1'b0;
    end
    check("wen_at_E0", 32'(write_en), 32'(legal));
    check("bvalid_at_E0", 32'(bus.s_bvalid), 32'd0);
    if (legal) shadow[addr[5:2]] = data;
    @(negedge clk);
    check("bvalid_at_E1", 32'(bus.s_bvalid), 32'd1);
    check("wen_clear_E1", 32'(write_en), 32'd0);
    resp0 = bus.s_bresp;
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      check("hold_bvalid", 32'(bus.s_bvalid), 32'd1);
      check("hold_bresp", 32'(bus.s_bresp), 32'(resp0));
      check("hold_awready", 32'(bus.s_awready), 32'd0);
      check("hold_wready", 32'(bus.s_wready), 32'd0);
    end
    bus.s_bready = 1'b1;
    exp_resp = b_q.pop_front();
    check("bresp", 32'(bus.s_bresp), 32'(exp_resp));
    @(negedge clk);
    bus.s_bready = 1'b0;
    check("bvalid_cleared", 32'(bus.s_bvalid), 32'd0);
    check("awready_back", 32'(bus.s_awready), 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_hold);
    logic        legal, ar_f;
    logic [31:0] d0;
    logic [1:0]  r0;
    rd_t         e;
    int          cyc;
    legal  = (addr < 32'h40);
    e.data = legal ? shadow[addr[5:2]] : 32'h0;
    e.resp = legal ? 2'b00 : 2'b10;
    r_q.push_back(e);
    bus.s_araddr  = addr;
    bus.s_arvalid = 1'b1;
    bus.s_rready  = 1'b0;
    cyc = 0;
    while (bus.s_arvalid && cyc < 40) begin
      ar_f = bus.s_arvalid && bus.s_arready;
      @(negedge clk);
      cyc++;
      if (ar_f) bus.s_arvalid = 1'b0;
    end
    if (bus.s_arvalid) begin
      check("ar_timeout", 32'(bus.s_arvalid), 32'd0);
      bus.s_arvalid = 1'b0;
    end
    check("read_addr", read_addr, addr);
    check("rvalid_E0", 32'(bus.s_rvalid), 32'd0);
    check("arready_E0", 32'(bus.s_arready), 32'd0);
    @(negedge clk);
    check("rvalid_E1", 32'(bus.s_rvalid), 32'd1);
    d0 = bus.s_rdata;
    r0 = bus.s_rresp;
    for (int i = 0; i < r_hold; i++) begin
      @(negedge clk);
      check("hold_rvalid", 32'(bus.s_rvalid), 32'd1);
      check("hold_rdata", bus.s_rdata, d0);
      check("hold_rresp", 32'(bus.s_rresp), 32'(r0));
      check("hold_arready", 32'(bus.s_arready), 32'd0);
    end
    bus.s_rready = 1'b1;
    e = r_q.pop_front();
    check("rdata", bus.s_rdata, e.data);
    check("rresp", 32'(bus.s_rresp), 32'(e.resp));
    @(negedge clk);
    bus.s_rready = 1'b0;
    check("rvalid_cleared", 32'(bus.s_rvalid), 32'd0);
    check("arready_back", 32'(bus.s_arready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
    bus.s_wdata = '0;  bus.s_wstrb = '0; bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b0;
    bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_awready", 32'(bus.s_awready), 32'd0);
    check("rst_wready", 32'(bus.s_wready), 32'd0);
    check("rst_arready", 32'(bus.s_arready), 32'd0);
    check("rst_bvalid", 32'(bus.s_bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.s_rvalid), 32'd0);
    check("rst_bresp", 32'(bus.s_bresp), 32'd0);
    check("rst_rresp", 32'(bus.s_rresp), 32'd0);
    check("rst_rdata", bus.s_rdata, 32'd0);
    check("rst_wen", 32'(write_en), 32'd0);
    check("rst_waddr", write_addr, 32'd0);
    check("rst_wdata", write_data, 32'd0);
    check("rst_raddr", read_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_awready", 32'(bus.s_awready), 32'd1);
    check("post_rst_arready", 32'(bus.s_arready), 32'd1);

    // Same-cycle AW/W, then W leading AW by three cycles
    axi_write(32'h00, 32'h0000_00A5, 4'hF, 0, 0);
    axi_write(32'h04, 32'h0000_0012, 4'hF, 3, 0);

    // Rejected writes: read-only index, out of range, partial strobe
    axi_write(32'h0C, 32'h0000_0099, 4'hF, 0, 0);
    axi_write(32'h40, 32'h0000_0077, 4'hF, 0, 0);
    axi_write(32'h08, 32'h0000_0033, 4'h3, 0, 0);

    axi_read(32'h40, 0);
    axi_read(32'h0C, 0);
    axi_read(32'h00, 0);
    axi_read(32'h04, 0);
    axi_read(32'h08, 0);
    axi_read(32'h3D, 0);

    // Backpressure on B and R
    axi_write(32'h18, 32'h0000_CAFE, 4'hF, 0, 5);
    axi_read(32'h18, 5);

    // Concurrent write and read of the same register
    fork
      axi_write(32'h10, 32'h0000_0055, 4'hF, 0, 0);
      axi_read(32'h10, 0);
    join
    axi_read(32'h10, 0);

    // Reset while in W_EXEC
    bus.s_awaddr = 32'h14; bus.s_wdata = 32'h0000_0077; bus.s_wstrb = 4'hF;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    check("exec_wen_pre_reset", 32'(write_en), 32'd1);
    reset = 1'b1;
    #1;
    check("exec_rst_wen", 32'(write_en), 32'd0);
    check("exec_rst_bvalid", 32'(bus.s_bvalid), 32'd0);
    check("exec_rst_awready", 32'(bus.s_awready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    axi_read(32'h14, 0);
    axi_write(32'h14, 32'h0000_0077, 4'hF, 0, 0);
    axi_read(32'h14, 0);

    // Reset while in R_DATA
    bus.s_araddr = 32'h00; bus.s_arvalid = 1'b1;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    @(negedge clk);
    check("rdata_state_rvalid", 32'(bus.s_rvalid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rdata_rst_rvalid", 32'(bus.s_rvalid), 32'd0);
    check("rdata_rst_rdata", bus.s_rdata, 32'd0);
    check("rdata_rst_arready", 32'(bus.s_arready), 32'd0);
    check("rdata_rst_bvalid", 32'(bus.s_bvalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    axi_read(32'h00, 0);
    axi_write(32'h1C, 32'h1234_5678, 4'hF, 0, 0);
    axi_read(32'h1C, 0);

    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
